// File: rtl/shift_pkg.sv
// Shared definitions for the lab-board shift register path.
// - key_state_e: state encoding of the key stepping front end.
// - OPT_*: operation codes understood by the downstream shift stage.
package shift_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StPressDb   = 2'd1,
    StHeld      = 2'd2,
    StReleaseDb = 2'd3
  } key_state_e;

  localparam logic [2:0] OPT_CLR    = 3'b000;
  localparam logic [2:0] OPT_LOAD   = 3'b001;
  localparam logic [2:0] OPT_SHR    = 3'b010;
  localparam logic [2:0] OPT_SHL    = 3'b011;
  localparam logic [2:0] OPT_ASR    = 3'b100;
  localparam logic [2:0] OPT_SHL_IN = 3'b101;
  localparam logic [2:0] OPT_ROR    = 3'b110;
  localparam logic [2:0] OPT_ROL    = 3'b111;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser for asynchronous inputs, synchronous active-high reset.
// Ports:
//   clk_i - destination clock
//   rst_i - synchronous reset, clears both flops
//   d_i   - asynchronous input
//   q_o   - synchronised output, two clk_i edges of latency
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_step_ctrl.sv
// Push-button stepping front end for the shift register stage. Synchronises and debounces
// key_in, emits a one-cycle step strobe per accepted press (plus optional auto-repeat while
// held) and latches the switch command on every step.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   key_in    - raw push button, asynchronous, 1 = pressed
//   repeat_en - allow auto-repeat while the button is held
//   sw_opt    - operation code from the switches
//   sw_data   - data byte from the switches
//   step      - registered one-cycle step strobe
//   opt       - operation code latched on each step
//   data_in   - data byte latched on each step
//   step_cnt  - number of steps issued, wraps at 256
module key_step_ctrl
  import shift_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  input  logic       repeat_en,
  input  logic [2:0] sw_opt,
  input  logic [7:0] sw_data,
  output logic       step,
  output logic [2:0] opt,
  output logic [7:0] data_in,
  output logic [7:0] step_cnt
);

  localparam logic [CNT_W-1:0] DbLast     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  logic key_s;

  sync_2ff u_key_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (key_in),
    .q_o   (key_s)
  );

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  // 0: waiting for the first repeat (REPEAT_DELAY), 1: later repeats (REPEAT_PERIOD)
  logic             rep_phase_q, rep_phase_d;
  logic             step_q, step_d;
  logic [2:0]       opt_q, opt_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       step_cnt_q, step_cnt_d;
  logic             fire;

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    fire        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (key_s) begin
          state_d  = StPressDb;
          db_cnt_d = '0;
        end
      end
      StPressDb: begin
        if (!key_s) begin
          state_d = StIdle;
        end else if (db_cnt_q == DbLast) begin
          state_d     = StHeld;
          fire        = 1'b1;
          rep_phase_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + CntOne;
        end
      end
      StHeld: begin
        if (!key_s) begin
          state_d  = StReleaseDb;
          db_cnt_d = '0;
        end else if (!repeat_en) begin
          rep_cnt_d = '0;
        end else if (rep_cnt_q == (rep_phase_q ? PeriodLast : DelayLast)) begin
          fire        = 1'b1;
          rep_phase_d = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + CntOne;
        end
      end
      StReleaseDb: begin
        if (key_s) begin
          // Bounce during release: back to held, repeat phase is kept.
          state_d   = StHeld;
          rep_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
          state_d = StIdle;
        end else begin
          db_cnt_d = db_cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase

    if (fire) begin
      rep_cnt_d = '0;
    end

    step_d     = fire;
    opt_d      = fire ? sw_opt : opt_q;
    data_d     = fire ? sw_data : data_q;
    step_cnt_d = fire ? step_cnt_q + 8'd1 : step_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      db_cnt_q    <= '0;
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
      step_q      <= 1'b0;
      opt_q       <= OPT_CLR;
      data_q      <= 8'h00;
      step_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
      step_q      <= step_d;
      opt_q       <= opt_d;
      data_q      <= data_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  assign step     = step_q;
  assign opt      = opt_q;
  assign data_in  = data_q;
  assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_key_step_ctrl.sv
// Scoreboard bench for key_step_ctrl with D=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
// Stimulus pushes the expected (edge, opt, data, count) of every step it provokes; a negedge
// monitor pops one entry per observed step. Edge numbers count posedges since time 0.
module tb_key_step_ctrl;
  import shift_pkg::*;

  localparam int unsigned D  = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned RP = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic       repeat_en;
  logic [2:0] sw_opt;
  logic [7:0] sw_data;
  logic       step;
  logic [2:0] opt;
  logic [7:0] data_in;
  logic [7:0] step_cnt;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         edge_no;
    logic [2:0] opt;
    logic [7:0] data;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  key_step_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .CNT_W           (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .repeat_en (repeat_en),
    .sw_opt    (sw_opt),
    .sw_data   (sw_data),
    .step      (step),
    .opt       (opt),
    .data_in   (data_in),
    .step_cnt  (step_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: step is sampled mid-cycle, so cyc is the edge that issued it.
  always @(negedge clk) begin : mon
    exp_t e;
    if (step === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_step: step seen at edge %0d, none expected", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.edge_no != cyc || e.opt !== opt || e.data !== data_in || e.cnt !== step_cnt) begin
          n_errors++;
          $display("FAIL step_match: got edge=%0d opt=%b data=%h cnt=%0d, want edge=%0d opt=%b data=%h cnt=%0d",
                   cyc, opt, data_in, step_cnt, e.edge_no, e.opt, e.data, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic expect_step(input int e, input logic [2:0] o, input logic [7:0] d,
                             input logic [7:0] c);
    exp_t x;
    x.edge_no = e;
    x.opt     = o;
    x.data    = d;
    x.cnt     = c;
    exp_q.push_back(x);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_step"}, int'(step), 0);
    check({tag, "_opt"}, int'(opt), 0);
    check({tag, "_data"}, int'(data_in), 0);
    check({tag, "_cnt"}, int'(step_cnt), 0);
  endtask

  task automatic do_reset(input string tag);
    rst       = 1'b1;
    key_in    = 1'b0;
    repeat_en = 1'b0;
    tick(3);
    rst = 1'b0;
    check_zero_outputs(tag);
  endtask

  function automatic logic [7:0] data_at(input int e);
    return 8'(e * 37 + 11);
  endfunction

  initial begin
    int e0;
    int f;
    int ed;
    rst       = 1'b1;
    key_in    = 1'b0;
    repeat_en = 1'b0;
    sw_opt    = OPT_CLR;
    sw_data   = 8'h00;

    // 1: single press, no repeat
    do_reset("rst1");
    sw_opt  = OPT_LOAD;
    sw_data = 8'hA5;
    e0      = cyc + 1;
    expect_step(e0 + 6, OPT_LOAD, 8'hA5, 8'd1);
    key_in = 1'b1;
    tick(20);
    key_in = 1'b0;
    tick(D + 6);
    check("s1_cnt", int'(step_cnt), 1);
    check("s1_opt", int'(opt), int'(OPT_LOAD));
    check("s1_data", int'(data_in), 8'hA5);
    check("s1_drain", exp_q.size(), 0);

    // 2: bounce during press debounce
    do_reset("rst2");
    sw_opt  = OPT_SHR;
    sw_data = 8'h3C;
    key_in  = 1'b1;
    tick(2);
    key_in = 1'b0;
    tick(1);
    key_in = 1'b1;
    e0     = cyc + 1;
    expect_step(e0 + 6, OPT_SHR, 8'h3C, 8'd1);
    tick(15);
    check("s2_cnt", int'(step_cnt), 1);
    key_in = 1'b0;
    tick(D + 6);
    check("s2_drain", exp_q.size(), 0);

    // 3: auto-repeat, first delay then period
    do_reset("rst3");
    repeat_en = 1'b1;
    sw_opt    = OPT_SHL;
    sw_data   = 8'h81;
    e0        = cyc + 1;
    expect_step(e0 + 6, OPT_SHL, 8'h81, 8'd1);
    expect_step(e0 + 14, OPT_SHL, 8'h81, 8'd2);
    expect_step(e0 + 17, OPT_SHL, 8'h81, 8'd3);
    expect_step(e0 + 20, OPT_SHL, 8'h81, 8'd4);
    expect_step(e0 + 23, OPT_SHL, 8'h81, 8'd5);
    key_in = 1'b1;
    tick(24);
    key_in = 1'b0;
    tick(20);
    check("s3_cnt", int'(step_cnt), 5);
    check("s3_drain", exp_q.size(), 0);

    // 4: bounce during release debounce
    do_reset("rst4");
    sw_opt  = OPT_ASR;
    sw_data = 8'h5A;
    e0      = cyc + 1;
    expect_step(e0 + 6, OPT_ASR, 8'h5A, 8'd1);
    key_in = 1'b1;
    tick(10);
    key_in = 1'b0;
    tick(2);
    key_in = 1'b1;
    tick(1);
    key_in = 1'b0;
    f      = cyc + 1;
    tick(6);
    check("s4_not_idle_early", int'(dut.state_q == StIdle), 0);
    tick(1);
    check("s4_idle_at_d2", int'(dut.state_q == StIdle), 1);
    tick(5);
    check("s4_cnt", int'(step_cnt), 1);
    check("s4_drain", exp_q.size(), 0);

    // 5: reset mid press debounce, then immediate new press
    do_reset("rst5");
    sw_opt  = OPT_SHL_IN;
    sw_data = 8'hC3;
    key_in  = 1'b1;
    e0      = cyc + 1;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_zero_outputs("s5_after_rst");
    expect_step(cyc + 7, OPT_SHL_IN, 8'hC3, 8'd1);
    tick(15);
    check("s5_cnt", int'(step_cnt), 1);
    key_in = 1'b0;
    tick(D + 6);
    check("s5_drain", exp_q.size(), 0);

    // 6: 256 repeat steps with per-cycle data, counter wraps
    do_reset("rst6");
    repeat_en = 1'b1;
    sw_opt    = OPT_ROR;
    e0        = cyc + 1;
    for (int k = 1; k <= 256; k++) begin
      ed = (k == 1) ? e0 + 6 : e0 + 14 + 3 * (k - 2);
      expect_step(ed, OPT_ROR, data_at(ed), 8'(k));
    end
    key_in = 1'b1;
    for (int i = 0; i < 777; i++) begin
      sw_data = data_at(cyc + 1);
      tick(1);
    end
    key_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sw_data = data_at(cyc + 1);
      tick(1);
    end
    check("s6_cnt_wrap", int'(step_cnt), 0);
    check("s6_opt", int'(opt), int'(OPT_ROR));
    check("s6_data_last", int'(data_in), int'(data_at(e0 + 776)));
    check("s6_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
